// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA display path.
//   H_VALID / V_VALID : visible raster size
//   PIX_INVALID       : coordinate value reported outside active video
//   wr_state_t        : write-port arbiter FSM states
//   is_vblank()       : vertical-blanking test on a pixel row
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int         H_VALID     = 640;
  localparam int         V_VALID     = 480;
  localparam logic [9:0] PIX_INVALID = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } wr_state_t;

  // Vertical blanking: the timing controller parks the row at PIX_INVALID.
  function automatic logic is_vblank(input logic [9:0] row);
    return (row == PIX_INVALID);
  endfunction

endpackage

// File: rtl/vga_wr_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req0, req1 : request lines
//   last       : index of the requester granted most recently
//   gnt_idx    : chosen requester (0 or 1), meaningful when gnt_vld = 1
//   gnt_vld    : at least one request present
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_idx,
  output logic gnt_vld
);

  assign gnt_vld = req0 | req1;

  // Under contention the requester that did not win last time goes next;
  // otherwise whoever is asking wins (req1 alone -> 1, req0 alone -> 0).
  assign gnt_idx = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/vga_wr_arb.sv
// -----------------------------------------------------------------------------
// vga_wr_arb
// Write-port arbiter for the VGA display buffer. Two requesters share the
// display RAM write port; writes are only granted during vertical blanking so
// they never collide with pixel reads.
//   vga_clk, sys_rst_n     : pixel clock, asynchronous active-low reset
//   pix_x, pix_y           : raster position (10'h3FF outside active video)
//   req/addr/data/ack 0,1  : requester handshakes, ack is a one-cycle pulse
//   ram_we/waddr/wdata     : RAM write port, ram_we qualifies addr/data
//   blank                  : registered write-window flag
//   wr_cnt                 : saturating count of writes in the current window
// -----------------------------------------------------------------------------
module vga_wr_arb
  import vga_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              blank,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wr_state_t state;
  logic      last;
  logic      gnt_idx;
  logic      gnt_vld;
  logic      blank_raw;
  logic      blank_rise;

  // The column is not needed for a vertical-blanking window.
  logic      unused_pix_x;
  assign unused_pix_x = ^pix_x;

  assign blank_raw  = is_vblank(pix_y);
  assign blank_rise = blank_raw & ~blank;

  rr_arb2 u_rr_arb2 (
    .req0    (req0),
    .req1    (req1),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blank <= 1'b0;
    end else begin
      blank <= blank_raw;
    end
  end

  // Cleared as the window opens, then held through active video so software
  // can read back how many writes the last window carried.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_cnt <= '0;
    end else if (blank_rise) begin
      wr_cnt <= '0;
    end else if (state == WRITE && wr_cnt != '1) begin
      wr_cnt <= wr_cnt + CNT_ONE;
    end
  end

  // IDLE -> WRITE -> GAP -> IDLE. The GAP cycle gives a requester that has
  // just seen ack time to drop req before requests are sampled again.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      ram_we    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blank && gnt_vld) begin
            state     <= WRITE;
            last      <= gnt_idx;
            ram_we    <= 1'b1;
            ack0      <= ~gnt_idx;
            ack1      <= gnt_idx;
            ram_waddr <= gnt_idx ? addr1 : addr0;
            ram_wdata <= gnt_idx ? data1 : data0;
          end
        end
        WRITE: begin
          state  <= GAP;
          ram_we <= 1'b0;
          ack0   <= 1'b0;
          ack1   <= 1'b0;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
          ack0   <= 1'b0;
          ack1   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_vga_wr_arb
// Self-checking bench for vga_wr_arb. Two instances share all stimulus: the
// default configuration and one with a 4-bit write counter for saturation.
// A transaction-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_vga_wr_arb;
  import vga_pkg::*;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    pix_x, pix_y;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;

  logic          ack0, ack1, ram_we, blank;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [15:0]   wr_cnt;

  logic          s_ack0, s_ack1, s_we, s_blank;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_cnt;

  always #5 clk = ~clk;

  vga_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .blank(blank), .wr_cnt(wr_cnt)
  );

  vga_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_sat (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(s_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(s_ack1),
    .ram_we(s_we), .ram_waddr(s_waddr), .ram_wdata(s_wdata),
    .blank(s_blank), .wr_cnt(s_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Rules: the window flag is pix_y==3FF delayed one cycle; a grant needs the
  // window flag, a pending request and at least 3 edges since the previous
  // grant; contention alternates away from the last winner.
  logic          m_blank, m_we, m_ack0, m_ack1, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_since, m_cnt, m_cnt4;

  logic rand_en   = 1'b0;
  logic hold_both = 1'b0;

  task automatic model_reset();
    m_blank = 1'b0; m_we = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0; m_last = 1'b1;
    m_addr = '0; m_data = '0; m_since = 3; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic new_req0();
    req0 = 1'b1; addr0 = AW'($urandom); data0 = DW'($urandom);
  endtask

  task automatic new_req1();
    req1 = 1'b1; addr1 = AW'($urandom); data1 = DW'($urandom);
  endtask

  // One clock: predict, sample #1 after the edge, compare, then advance the
  // requesters' handshakes.
  task automatic step();
    logic nb;
    logic w;
    @(posedge clk);
    cyc++;
    nb = (pix_y == PIX_INVALID);
    if (nb && !m_blank) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (m_we) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (m_since < 3) m_since++;
    m_we = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
    if (m_since == 3 && m_blank && (req0 || req1)) begin
      if (req0 && req1) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else              w = req1;
      m_we = 1'b1; m_since = 0; m_last = w;
      m_ack0 = (w == 1'b0); m_ack1 = (w == 1'b1);
      m_addr = w ? addr1 : addr0;
      m_data = w ? data1 : data0;
    end
    m_blank = nb;
    #1;
    check_val("blank",    blank,     m_blank);
    check_val("ram_we",   ram_we,    m_we);
    check_val("ack0",     ack0,      m_ack0);
    check_val("ack1",     ack1,      m_ack1);
    check_val("waddr",    ram_waddr, m_addr);
    check_val("wdata",    ram_wdata, m_data);
    check_val("wr_cnt",   wr_cnt,    m_cnt);
    check_val("sat_we",   s_we,      m_we);
    check_val("sat_cnt",  s_cnt,     m_cnt4);
    if (m_ack0) begin
      req0 = 1'b0;
      if (hold_both || (rand_en && $urandom_range(1) == 0)) new_req0();
    end else if (!req0 && rand_en && $urandom_range(2) == 0) begin
      new_req0();
    end
    if (m_ack1) begin
      req1 = 1'b0;
      if (hold_both || (rand_en && $urandom_range(1) == 0)) new_req1();
    end else if (!req1 && rand_en && $urandom_range(2) == 0) begin
      new_req1();
    end
  endtask

  task automatic set_active();
    pix_y = 10'($urandom_range(V_VALID - 1));
    pix_x = 10'($urandom_range(H_VALID - 1));
  endtask

  task automatic set_blank();
    pix_y = PIX_INVALID;
    pix_x = PIX_INVALID;
  endtask

  int ord[6];
  int at[6];
  int n_got;
  int seen;

  initial begin
    rst_n = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    model_reset();
    #2;
    check_val("rst_we",    ram_we,    0);
    check_val("rst_ack0",  ack0,      0);
    check_val("rst_ack1",  ack1,      0);
    check_val("rst_blank", blank,     0);
    check_val("rst_waddr", ram_waddr, 0);
    check_val("rst_wdata", ram_wdata, 0);
    check_val("rst_cnt",   wr_cnt,    0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Active video hold-off, then one write two edges after the window opens.
    pix_y = 10'd100; pix_x = 10'd5;
    req0 = 1'b1; addr0 = 13'h0010; data0 = 16'hF800;
    seen = 0;
    repeat (10) begin
      step();
      if (ram_we) seen++;
    end
    check_val("holdoff_we", seen, 0);
    set_blank();
    step();
    check_val("lag_we", ram_we, 0);
    step();
    check_val("first_we",    ram_we,    1);
    check_val("first_ack0",  ack0,      1);
    check_val("first_addr",  ram_waddr, 13'h0010);
    check_val("first_data",  ram_wdata, 16'hF800);
    step(); step();
    check_val("first_cnt",   wr_cnt,    1);

    // Reset asynchronously while a write is on the port.
    new_req1();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (ram_we) seen = 1;
    end
    check_val("midwrite_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_we",    ram_we,    0);
    check_val("arst_ack1",  ack1,      0);
    check_val("arst_blank", blank,     0);
    check_val("arst_waddr", ram_waddr, 0);
    check_val("arst_wdata", ram_wdata, 0);
    check_val("arst_cnt",   wr_cnt,    0);
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    pix_y = 10'd200;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention: both held continuously, six grants in one window.
    new_req0(); new_req1(); hold_both = 1'b1;
    repeat (3) step();
    set_blank();
    n_got = 0;
    for (int i = 0; i < 40 && n_got < 6; i++) begin
      step();
      if (ram_we) begin
        ord[n_got] = ack1 ? 1 : 0;
        at[n_got]  = cyc;
        n_got++;
        if (n_got == 6) pix_y = 10'd200;
      end
    end
    check_val("cont_count", n_got, 6);
    hold_both = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < n_got; i++) begin
      check_val("cont_order", ord[i], i % 2);
      if (i > 0) check_val("cont_spacing", at[i] - at[i-1], 3);
    end
    repeat (4) step();
    check_val("cont_cnt", wr_cnt, 6);

    // Window closes right after a grant; the other request waits a frame.
    new_req0(); new_req1();
    set_blank();
    step();
    pix_y = 10'd300;
    step();
    check_val("close_we",    ram_we, 1);
    check_val("close_ack0",  ack0,   1);
    check_val("close_blank", blank,  0);
    seen = 0;
    repeat (10) begin
      step();
      if (ram_we) seen++;
    end
    check_val("close_nowrite", seen, 0);
    check_val("close_cnt",     wr_cnt, 1);
    set_blank();
    step();
    check_val("reopen_clear", wr_cnt, 0);
    step();
    check_val("reopen_ack1",  ack1,   1);
    step(); step();
    check_val("reopen_cnt",   wr_cnt, 1);
    pix_y = 10'd10;
    repeat (3) step();

    // Saturation of the 4-bit counter over a long window.
    new_req0(); new_req1(); hold_both = 1'b1;
    set_blank();
    repeat (70) step();
    pix_y = 10'd20;
    hold_both = 1'b0;
    repeat (3) step();
    req0 = 1'b0; req1 = 1'b0;
    check_val("sat_final", s_cnt, 4'hF);
    check_val("sat_wide_over20", (wr_cnt >= 16'd20) ? 1 : 0, 1);

    // Randomised frames with randomly arriving requests.
    rand_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(30, 4)) begin
        set_active();
        step();
      end
      set_blank();
      repeat ($urandom_range(25, 1)) step();
    end
    rand_en = 1'b0;
    set_active();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
